// File: rtl/sfp_link_monitor.sv
`default_nettype none
// sfp_link_monitor: SFP cage pin synchroniser/debouncer, link state machine,
// TX-disable control and saturating link-drop counter.  Rev 1.0
module sfp_link_monitor #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SETTLE_CYCLES   = 30000000,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 detect,
    input  logic                 los,
    input  logic                 i_shutdown,
    input  logic                 clr_count,
    output logic                 shutdown,
    output logic                 o_detect,
    output logic                 o_los,
    output logic                 link_up,
    output logic [1:0]           state,
    output logic                 link_change,
    output logic [CNT_WIDTH-1:0] link_drops
);

    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    // Bit 0 carries detect, bit 1 carries los; los idles high (no light).
    localparam logic [1:0] RST_VAL = 2'b10;

    typedef enum logic [1:0] {
        ABSENT   = 2'd0,
        SETTLE   = 2'd1,
        NO_LIGHT = 2'd2,
        LINK_UP  = 2'd3
    } state_t;

    logic [1:0] raw_in;
    logic [1:0] deb;
    assign raw_in = {los, detect};

    generate
        for (genvar g = 0; g < 2; g++) begin : g_cond
            logic [SYNC_STAGES-1:0] sync_ff;
            logic [DB_W-1:0]        db_cnt;
            logic                   deb_val;
            logic                   sync_out;

            assign sync_out = sync_ff[SYNC_STAGES-1];
            assign deb[g]   = deb_val;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sync_ff <= {SYNC_STAGES{RST_VAL[g]}};
                    db_cnt  <= '0;
                    deb_val <= RST_VAL[g];
                end else begin
                    sync_ff <= {sync_ff[SYNC_STAGES-2:0], raw_in[g]};
                    if (sync_out == deb_val) begin
                        db_cnt <= '0;
                    end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        deb_val <= sync_out;
                        db_cnt  <= '0;
                    end else begin
                        db_cnt <= db_cnt + DB_W'(1);
                    end
                end
            end
        end
    endgenerate

    state_t           st;
    logic [SET_W-1:0] settle_cnt;
    logic             d_det;
    logic             d_los;

    assign d_det    = deb[0];
    assign d_los    = deb[1];
    assign o_detect = d_det;
    assign o_los    = d_los;
    assign state    = st;
    assign link_up  = (st == LINK_UP);

    // Removal is tested first in every state so it overrides all other exits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st          <= ABSENT;
            settle_cnt  <= '0;
            shutdown    <= 1'b1;
            link_change <= 1'b0;
            link_drops  <= '0;
        end else begin
            link_change <= 1'b0;
            shutdown    <= (st == ABSENT) || (st == SETTLE) || i_shutdown;
            case (st)
                ABSENT: begin
                    if (d_det) begin
                        st         <= SETTLE;
                        settle_cnt <= '0;
                    end
                end
                SETTLE: begin
                    if (!d_det) begin
                        st <= ABSENT;
                    end else if (settle_cnt == SET_W'(SETTLE_CYCLES - 1)) begin
                        if (d_los) begin
                            st <= NO_LIGHT;
                        end else begin
                            st          <= LINK_UP;
                            link_change <= 1'b1;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + SET_W'(1);
                    end
                end
                NO_LIGHT: begin
                    if (!d_det) begin
                        st <= ABSENT;
                    end else if (!d_los) begin
                        st          <= LINK_UP;
                        link_change <= 1'b1;
                    end
                end
                LINK_UP: begin
                    if (!d_det) begin
                        st          <= ABSENT;
                        link_change <= 1'b1;
                    end else if (d_los) begin
                        st          <= NO_LIGHT;
                        link_change <= 1'b1;
                    end
                end
                default: st <= ABSENT;
            endcase

            if (clr_count) begin
                link_drops <= '0;
            end else if ((st == LINK_UP) && d_det && d_los && (link_drops != '1)) begin
                link_drops <= link_drops + CNT_WIDTH'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sfp_link_monitor.sv
`default_nettype none
// tb_sfp_link_monitor: table-driven, directed and randomized checks against a
// cycle-level reference model of the cage monitor.
module tb_sfp_link_monitor;

    localparam int SS = 2;
    localparam int DB = 4;
    localparam int SC = 16;
    localparam int CW = 4;
    localparam int DMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          detect = 1'b0;
    logic          los = 1'b1;
    logic          i_shutdown = 1'b0;
    logic          clr_count = 1'b0;
    logic          shutdown, o_detect, o_los, link_up, link_change;
    logic [1:0]    state;
    logic [CW-1:0] link_drops;

    sfp_link_monitor #(
        .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB), .SETTLE_CYCLES(SC), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .detect(detect), .los(los),
        .i_shutdown(i_shutdown), .clr_count(clr_count), .shutdown(shutdown),
        .o_detect(o_detect), .o_los(o_los), .link_up(link_up), .state(state),
        .link_change(link_change), .link_drops(link_drops)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: pins delayed by a sample history, debounce as
    // "last DB synchronised samples all disagree", settle as elapsed time.
    logic [1:0] hist[$];
    logic [1:0] win[$];
    logic [1:0] m_deb;
    int         m_state, m_start, m_cyc, m_drops;
    bit         m_shut, m_lc;

    function automatic void model_reset();
        hist.delete();
        win.delete();
        for (int i = 0; i < SS; i++) hist.push_back(2'b10);
        for (int i = 0; i < DB; i++) win.push_back(2'b10);
        m_deb = 2'b10; m_state = 0; m_start = 0; m_cyc = 0;
        m_drops = 0; m_shut = 1'b1; m_lc = 1'b0;
    endfunction

    function automatic void model_step(bit d, bit l, bit ish, bit clr);
        logic [1:0] s_old, od;
        int os, ns;
        bit all_diff;
        m_cyc++;
        s_old = hist.pop_front();
        hist.push_back({l, d});
        void'(win.pop_front());
        win.push_back(s_old);
        od = m_deb;
        for (int ch = 0; ch < 2; ch++) begin
            all_diff = 1'b1;
            foreach (win[k]) if (win[k][ch] == od[ch]) all_diff = 1'b0;
            if (all_diff) m_deb[ch] = ~od[ch];
        end
        os = m_state;
        ns = os;
        if (!od[0]) ns = 0;
        else begin
            case (os)
                0: begin ns = 1; m_start = m_cyc; end
                1: if (m_cyc - m_start == SC) ns = od[1] ? 2 : 3;
                2: if (!od[1]) ns = 3;
                default: if (od[1]) ns = 2;
            endcase
        end
        m_shut = (os <= 1) || ish;
        m_lc   = (os == 3) != (ns == 3);
        if (clr) m_drops = 0;
        else if (os == 3 && ns == 2 && m_drops < DMAX) m_drops++;
        m_state = ns;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        logic [10:0] dv, mv;
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step(detect, los, i_shutdown, clr_count);
        #1;
        dv = {shutdown, o_detect, o_los, link_up, state, link_change, link_drops};
        mv = {m_shut, m_deb[0], m_deb[1], (m_state == 3), m_state[1:0], m_lc, m_drops[CW-1:0]};
        check("model", int'(dv), int'(mv));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_shutdown"}, int'(shutdown), 1);
        check({tag, "_o_detect"}, int'(o_detect), 0);
        check({tag, "_o_los"}, int'(o_los), 1);
        check({tag, "_link_up"}, int'(link_up), 0);
        check({tag, "_state"}, int'(state), 0);
        check({tag, "_link_change"}, int'(link_change), 0);
        check({tag, "_link_drops"}, int'(link_drops), 0);
    endtask

    typedef struct {
        bit det, los, ish, clr;
        int n;
        bit e_det, e_los;
        int e_st;
        bit e_shut, e_lc;
        int e_drops;
    } vec_t;

    vec_t tbl[14];
    int   hold;

    initial begin
        // insertion, glitch rejection, light loss/return, user TX disable
        tbl[0]  = '{1,0,0,0, 5, 0,1,0,1,0,0};
        tbl[1]  = '{1,0,0,0, 1, 1,0,0,1,0,0};
        tbl[2]  = '{1,0,0,0, 1, 1,0,1,1,0,0};
        tbl[3]  = '{1,0,0,0,15, 1,0,1,1,0,0};
        tbl[4]  = '{1,0,0,0, 1, 1,0,3,1,1,0};
        tbl[5]  = '{1,0,0,0, 1, 1,0,3,0,0,0};
        tbl[6]  = '{1,1,0,0, 3, 1,0,3,0,0,0};
        tbl[7]  = '{1,0,0,0, 8, 1,0,3,0,0,0};
        tbl[8]  = '{1,1,0,0, 6, 1,1,3,0,0,0};
        tbl[9]  = '{1,1,0,0, 1, 1,1,2,0,1,1};
        tbl[10] = '{1,0,0,0, 6, 1,0,2,0,0,1};
        tbl[11] = '{1,0,0,0, 1, 1,0,3,0,1,1};
        tbl[12] = '{1,0,1,0, 1, 1,0,3,1,0,1};
        tbl[13] = '{1,0,0,0, 1, 1,0,3,0,0,1};

        model_reset();
        ticks(2);
        check_reset_vals("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            detect = tbl[i].det; los = tbl[i].los;
            i_shutdown = tbl[i].ish; clr_count = tbl[i].clr;
            ticks(tbl[i].n);
            check($sformatf("tbl%0d_o_detect", i), int'(o_detect), int'(tbl[i].e_det));
            check($sformatf("tbl%0d_o_los", i), int'(o_los), int'(tbl[i].e_los));
            check($sformatf("tbl%0d_state", i), int'(state), tbl[i].e_st);
            check($sformatf("tbl%0d_link_up", i), int'(link_up), int'(tbl[i].e_st == 3));
            check($sformatf("tbl%0d_shutdown", i), int'(shutdown), int'(tbl[i].e_shut));
            check($sformatf("tbl%0d_link_change", i), int'(link_change), int'(tbl[i].e_lc));
            check($sformatf("tbl%0d_link_drops", i), int'(link_drops), tbl[i].e_drops);
        end

        // removal from LINK_UP: no drop counted, change pulse
        detect = 1'b0;
        ticks(6);
        check("rm_state_hold", int'(state), 3);
        tick();
        check("rm_state", int'(state), 0);
        check("rm_link_change", int'(link_change), 1);
        check("rm_drops", int'(link_drops), 1);
        tick();
        check("rm_shutdown", int'(shutdown), 1);

        // removal at settle count 8, then a full fresh settle
        detect = 1'b1;
        ticks(7);
        check("ins_state", int'(state), 1);
        ticks(8);
        detect = 1'b0;
        ticks(6);
        check("mid_settle_state", int'(state), 1);
        tick();
        check("mid_abort_state", int'(state), 0);
        check("mid_abort_shutdown", int'(shutdown), 1);
        detect = 1'b1;
        ticks(7);
        check("reins_state", int'(state), 1);
        ticks(15);
        check("reins_settle_state", int'(state), 1);
        check("reins_settle_shutdown", int'(shutdown), 1);
        tick();
        check("reins_linkup", int'(state), 3);
        tick();
        check("reins_shutdown", int'(shutdown), 0);

        // drop counter saturation, then clear beating a same-cycle drop
        for (int i = 0; i < 16; i++) begin
            los = 1'b1; ticks(7);
            los = 1'b0; ticks(7);
        end
        check("sat_drops", int'(link_drops), 15);
        check("sat_state", int'(state), 3);
        los = 1'b1;
        ticks(6);
        clr_count = 1'b1;
        tick();
        clr_count = 1'b0;
        check("clr_state", int'(state), 2);
        check("clr_drops", int'(link_drops), 0);
        los = 1'b0;
        ticks(7);
        check("relink_state", int'(state), 3);

        // one-cycle reset in LINK_UP with the module still present
        rst_n = 1'b0;
        tick();
        check_reset_vals("midrst");
        rst_n = 1'b1;
        ticks(5);
        check("post_rst_det_early", int'(o_detect), 0);
        tick();
        check("post_rst_det", int'(o_detect), 1);
        check("post_rst_los", int'(o_los), 0);
        tick();
        check("post_rst_settle", int'(state), 1);
        ticks(15);
        check("post_rst_not_up", int'(link_up), 0);
        tick();
        check("post_rst_up", int'(link_up), 1);

        // randomized pins, user disable, clears and rare resets
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                detect = ($urandom_range(0, 7) != 0);
                los    = ($urandom_range(0, 2) == 0);
                hold   = $urandom_range(1, 30);
            end
            hold--;
            i_shutdown = ($urandom_range(0, 15) == 0);
            clr_count  = ($urandom_range(0, 99) == 0);
            rst_n      = ($urandom_range(0, 999) != 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
